// File: rtl/calc_pkg.sv
// Shared constants and types for the calculator key-entry front end:
// key codes, operator encoding and the entry FSM states.
package calc_pkg;

    localparam logic [3:0] KEY_ADD    = 4'd10;
    localparam logic [3:0] KEY_SUB    = 4'd11;
    localparam logic [3:0] KEY_MUL    = 4'd12;
    localparam logic [3:0] KEY_AND    = 4'd13;
    localparam logic [3:0] KEY_EQUALS = 4'd14;
    localparam logic [3:0] KEY_CLEAR  = 4'd15;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_AND = 2'd3
    } opcode_t;

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        ISSUE   = 2'd2
    } state_t;

endpackage

// File: rtl/calc_sync2.sv
// Two-flop synchronizer, parameterised width, asynchronously cleared to 0.
module calc_sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/calc_key_entry.sv
// Key entry stage: synchronizes raw key presses, accumulates decimal operands
// and an operator, and issues an (A, op, B) job over a valid/ready handshake.
module calc_key_entry
    import calc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       key_code,
    input  logic             key_valid,
    output logic [WIDTH-1:0] operand_a,
    output logic [WIDTH-1:0] operand_b,
    output logic [1:0]       opcode,
    output logic             op_valid,
    input  logic             op_ready,
    output logic [WIDTH-1:0] entry_value,
    output logic             entry_ovf
);

    // Returns {overflow, value}; on overflow the accumulator is returned unchanged.
    function automatic logic [WIDTH:0] accum_digit(input logic [WIDTH-1:0] acc,
                                                   input logic [3:0]       digit);
        logic [WIDTH+3:0] sum;
        sum = {4'b0000, acc} * (WIDTH+4)'(10) + {{WIDTH{1'b0}}, digit};
        if (sum > {4'b0000, {WIDTH{1'b1}}})
            return {1'b1, acc};
        else
            return {1'b0, sum[WIDTH-1:0]};
    endfunction

    logic [3:0]       code_s;
    logic             vld_s;
    logic             vld_prev;
    logic             key_evt;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] acc_a, acc_a_nxt;
    logic [WIDTH-1:0] acc_b, acc_b_nxt;
    opcode_t          op_q, op_nxt;
    logic             ovf, ovf_nxt;

    logic [WIDTH:0]   dig_res;
    logic [3:0]       op_diff;
    logic             is_digit;
    logic             is_oper;

    calc_sync2 #(.W(4)) u_sync_code (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (key_code),
        .q     (code_s)
    );

    calc_sync2 #(.W(1)) u_sync_valid (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (key_valid),
        .q     (vld_s)
    );

    assign key_evt  = vld_s & ~vld_prev;
    assign is_digit = (code_s <= 4'd9);
    assign is_oper  = (code_s >= KEY_ADD) && (code_s <= KEY_AND);
    assign op_diff  = code_s - KEY_ADD;
    assign dig_res  = accum_digit((state == ENTER_B) ? acc_b : acc_a, code_s);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_prev <= 1'b0;
            state    <= ENTER_A;
            acc_a    <= '0;
            acc_b    <= '0;
            op_q     <= OP_ADD;
            ovf      <= 1'b0;
        end else begin
            vld_prev <= vld_s;
            state    <= state_nxt;
            acc_a    <= acc_a_nxt;
            acc_b    <= acc_b_nxt;
            op_q     <= op_nxt;
            ovf      <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_a_nxt = acc_a;
        acc_b_nxt = acc_b;
        op_nxt    = op_q;
        ovf_nxt   = ovf;
        case (state)
            ENTER_A: begin
                if (key_evt) begin
                    if (is_digit) begin
                        acc_a_nxt = dig_res[WIDTH-1:0];
                        if (dig_res[WIDTH]) ovf_nxt = 1'b1;
                    end else if (is_oper) begin
                        op_nxt    = opcode_t'(op_diff[1:0]);
                        acc_b_nxt = '0;
                        state_nxt = ENTER_B;
                    end else if (code_s == KEY_CLEAR) begin
                        acc_a_nxt = '0;
                        ovf_nxt   = 1'b0;
                    end
                end
            end
            ENTER_B: begin
                if (key_evt) begin
                    if (is_digit) begin
                        acc_b_nxt = dig_res[WIDTH-1:0];
                        if (dig_res[WIDTH]) ovf_nxt = 1'b1;
                    end else if (is_oper) begin
                        op_nxt = opcode_t'(op_diff[1:0]);
                    end else if (code_s == KEY_EQUALS) begin
                        state_nxt = ISSUE;
                    end else begin
                        acc_a_nxt = '0;
                        acc_b_nxt = '0;
                        op_nxt    = OP_ADD;
                        ovf_nxt   = 1'b0;
                        state_nxt = ENTER_A;
                    end
                end
            end
            ISSUE: begin
                // Keys are ignored here; only the handshake moves us on.
                if (op_ready) begin
                    acc_a_nxt = '0;
                    acc_b_nxt = '0;
                    ovf_nxt   = 1'b0;
                    state_nxt = ENTER_A;
                end
            end
            default: state_nxt = ENTER_A;
        endcase
    end

    assign op_valid    = (state == ISSUE);
    assign operand_a   = acc_a;
    assign operand_b   = acc_b;
    assign opcode      = op_q;
    assign entry_value = (state == ENTER_B) ? acc_b : acc_a;
    assign entry_ovf   = ovf;

endmodule

// File: tb/tb_calc_key_entry.sv
// Directed bench for calc_key_entry: expected jobs go into a scoreboard queue
// and a monitor compares every accepted job; entry state is checked directly.
module tb_calc_key_entry;

    localparam int WIDTH = 8;

    typedef struct {
        int unsigned a;
        int unsigned b;
        int unsigned op;
    } job_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [3:0]       key_code = 4'd0;
    logic             key_valid = 1'b0;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic [1:0]       opcode;
    logic             op_valid;
    logic             op_ready = 1'b0;
    logic [WIDTH-1:0] entry_value;
    logic             entry_ovf;

    int   checks = 0;
    int   errors = 0;
    job_t exp_q[$];

    calc_key_entry #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .opcode      (opcode),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .entry_value (entry_value),
        .entry_ovf   (entry_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic [3:0] code);
        key_code = code;
        cycles(2);
        key_valid = 1'b1;
        cycles(3);
        key_valid = 1'b0;
        cycles(5);
    endtask

    task automatic expect_job(input int unsigned a, input int unsigned b, input int unsigned op);
        job_t j;
        j.a  = a;
        j.b  = b;
        j.op = op;
        exp_q.push_back(j);
    endtask

    // Monitor: a job is accepted at the next rising edge when valid and ready are both high.
    always @(negedge clk) begin
        if (rst_n && op_valid && op_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL job_unexpected: got a=%0d b=%0d op=%0d expected no job",
                         operand_a, operand_b, opcode);
            end else begin
                job_t e;
                e = exp_q.pop_front();
                if (operand_a !== e.a[WIDTH-1:0] || operand_b !== e.b[WIDTH-1:0] ||
                    opcode !== e.op[1:0]) begin
                    errors++;
                    $display("FAIL job: got a=%0d b=%0d op=%0d expected a=%0d b=%0d op=%0d",
                             operand_a, operand_b, opcode, e.a, e.b, e.op);
                end
            end
        end
    end

    initial begin
        // Reset state
        cycles(3);
        chk("rst_op_valid", op_valid, 0);
        chk("rst_operand_a", operand_a, 0);
        chk("rst_operand_b", operand_b, 0);
        chk("rst_opcode", opcode, 0);
        chk("rst_entry_value", entry_value, 0);
        chk("rst_entry_ovf", entry_ovf, 0);
        rst_n = 1'b1;
        cycles(2);

        // 12 + 34 with the core always ready
        op_ready = 1'b1;
        press(4'd1);
        press(4'd2);
        chk("t1_entry_a", entry_value, 12);
        press(4'd10);
        press(4'd3);
        press(4'd4);
        chk("t1_entry_b", entry_value, 34);
        expect_job(12, 34, 0);
        press(4'd14);
        chk("t1_valid_after", op_valid, 0);
        chk("t1_entry_after", entry_value, 0);

        // Overflow rejection and sticky flag
        press(4'd15);
        press(4'd2);
        press(4'd5);
        chk("t2_entry_25", entry_value, 25);
        chk("t2_ovf_clear", entry_ovf, 0);
        press(4'd6);
        chk("t2_entry_kept", entry_value, 25);
        chk("t2_ovf_set", entry_ovf, 1);
        press(4'd5);
        chk("t2_entry_255", entry_value, 255);
        chk("t2_ovf_sticky", entry_ovf, 1);
        press(4'd15);
        chk("t2_ovf_cleared", entry_ovf, 0);
        chk("t2_entry_cleared", entry_value, 0);

        // 9 * 7 with a stalled core
        op_ready = 1'b0;
        press(4'd9);
        press(4'd12);
        press(4'd7);
        expect_job(9, 7, 2);
        press(4'd14);
        for (int i = 0; i < 10; i++) begin
            chk("t3_stall_valid", op_valid, 1);
            chk("t3_stall_a", operand_a, 9);
            chk("t3_stall_b", operand_b, 7);
            chk("t3_stall_op", opcode, 2);
            cycles(1);
        end
        press(4'd3);
        chk("t3_digit_valid", op_valid, 1);
        chk("t3_digit_a", operand_a, 9);
        chk("t3_digit_b", operand_b, 7);
        chk("t3_digit_entry", entry_value, 9);
        op_ready = 1'b1;
        cycles(2);
        chk("t3_valid_after", op_valid, 0);
        chk("t3_entry_after", entry_value, 0);

        // Operator overwrite, then CLEAR from ENTER_B
        press(4'd4);
        press(4'd10);
        press(4'd5);
        press(4'd11);
        chk("t4_opcode_sub", opcode, 1);
        chk("t4_entry_b", entry_value, 5);
        press(4'd15);
        chk("t4_clear_a", operand_a, 0);
        chk("t4_clear_b", operand_b, 0);
        chk("t4_clear_op", opcode, 0);
        chk("t4_clear_entry", entry_value, 0);
        press(4'd3);
        chk("t4_final_a", operand_a, 3);
        chk("t4_final_entry", entry_value, 3);

        // Long hold yields one event
        press(4'd15);
        key_code = 4'd7;
        cycles(2);
        key_valid = 1'b1;
        cycles(20);
        key_valid = 1'b0;
        cycles(5);
        chk("t5_single_event", entry_value, 7);

        // Reset while a job is pending loses the job
        op_ready = 1'b0;
        press(4'd15);
        press(4'd1);
        press(4'd10);
        press(4'd2);
        press(4'd14);
        chk("t6_issue_valid", op_valid, 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", op_valid, 0);
        chk("t6_rst_a", operand_a, 0);
        chk("t6_rst_b", operand_b, 0);
        chk("t6_rst_op", opcode, 0);
        chk("t6_rst_entry", entry_value, 0);
        chk("t6_rst_ovf", entry_ovf, 0);
        cycles(2);
        rst_n = 1'b1;
        op_ready = 1'b1;
        cycles(2);
        press(4'd1);
        press(4'd14);
        cycles(3);
        chk("t6_no_job_valid", op_valid, 0);
        chk("t6_entry_one", entry_value, 1);

        chk("jobs_left", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
